// File: rtl/bcd_digit_serializer_if.sv
// ----------------------------------------------------------------------------
// bcd_digit_serializer_if
//   Handshake bundle between a packed-BCD word source, the digit serializer
//   and the downstream digit consumer.
//
//   Signals:
//     in_valid   source -> serializer   BCD_code is valid this cycle
//     in_ready   serializer -> source   serializer can accept a word
//     BCD_code   source -> serializer   packed BCD word, nibble DIGIT-1 is MSD
//     out_valid  serializer -> sink     out_digit/out_last are valid
//     out_ready  sink -> serializer     sink accepts the current digit
//     out_digit  serializer -> sink     current decimal digit 0-9
//     out_last   serializer -> sink     current digit is the units digit
//     err        serializer -> sink     one-cycle pulse: word had a nibble > 9
//
//   Modports:
//     master  testbench / surrounding logic side
//     slave   serializer side
// ----------------------------------------------------------------------------
interface bcd_digit_serializer_if #(
  parameter int unsigned DIGIT = 7
);
  logic               in_valid;
  logic               in_ready;
  logic [DIGIT*4-1:0] BCD_code;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         out_digit;
  logic               out_last;
  logic               err;

  modport master (
    output in_valid,
    output BCD_code,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_digit,
    input  out_last,
    input  err
  );

  modport slave (
    input  in_valid,
    input  BCD_code,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_digit,
    output out_last,
    output err
  );
endinterface

// File: rtl/bcd_digit_serializer.sv
// ----------------------------------------------------------------------------
// bcd_digit_serializer
//   Accepts one packed BCD word per valid/ready handshake and streams its
//   decimal digits out one per handshake, most significant first. Leading
//   zeros are optionally suppressed (an all-zero word still yields a single
//   0). Words containing a nibble above 9 are dropped and flagged with a
//   one-cycle err pulse.
//
//   Parameters:
//     DIGIT  number of BCD digits in the input word
//     LZS    1 = suppress leading zero digits, 0 = always emit DIGIT digits
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    bcd_digit_serializer_if.slave (input word and digit streams)
//
//   All outputs are registered except in_ready, which is decoded from the
//   state register alone.
// ----------------------------------------------------------------------------
module bcd_digit_serializer #(
  parameter int unsigned DIGIT = 7,
  parameter int unsigned LZS   = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  bcd_digit_serializer_if.slave bus
);

  localparam int unsigned IW = (DIGIT > 1) ? $clog2(DIGIT) : 1;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

  state_e             r_state, w_state_d;
  logic [DIGIT*4-1:0] r_word,  w_word_d;
  logic [IW-1:0]      r_idx,   w_idx_d;
  logic [3:0]         r_digit, w_digit_d;
  logic               r_last,  w_last_d;
  logic               r_valid, w_valid_d;
  logic               r_err,   w_err_d;

  logic               w_bad;
  logic [IW-1:0]      w_start;
  logic [IW-1:0]      w_idx_m1;

  // Any nibble above 9 makes the whole word invalid.
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      if (bus.BCD_code[i*4 +: 4] > 4'd9) begin
        w_bad = 1'b1;
      end
    end
  end

  // Start index: highest nonzero nibble (ascending scan, last hit wins), or
  // 0 for an all-zero word. Without suppression always start at the MSD.
  always_comb begin
    w_start = IW'(DIGIT - 1);
    if (LZS != 0) begin
      w_start = '0;
      for (int i = 0; i < int'(DIGIT); i++) begin
        if (bus.BCD_code[i*4 +: 4] != 4'd0) begin
          w_start = IW'(i);
        end
      end
    end
  end

  assign w_idx_m1 = r_idx - IW'(1);

  always_comb begin
    w_state_d = r_state;
    w_word_d  = r_word;
    w_idx_d   = r_idx;
    w_digit_d = r_digit;
    w_last_d  = r_last;
    w_valid_d = r_valid;
    w_err_d   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          w_word_d = bus.BCD_code;
          if (w_bad) begin
            // Drop the word; stay idle so the next word can be taken.
            w_err_d = 1'b1;
          end else begin
            w_state_d = StSend;
            w_idx_d   = w_start;
            w_digit_d = bus.BCD_code[w_start*4 +: 4];
            w_last_d  = (w_start == '0);
            w_valid_d = 1'b1;
          end
        end
      end

      StSend: begin
        if (bus.out_ready) begin
          if (r_idx == '0) begin
            w_state_d = StIdle;
            w_valid_d = 1'b0;
            w_last_d  = 1'b0;
            w_digit_d = 4'd0;
          end else begin
            w_idx_d   = w_idx_m1;
            w_digit_d = r_word[w_idx_m1*4 +: 4];
            w_last_d  = (w_idx_m1 == '0);
          end
        end
      end

      default: begin
        w_state_d = StIdle;
        w_valid_d = 1'b0;
        w_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_word  <= '0;
      r_idx   <= '0;
      r_digit <= 4'd0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_word  <= w_word_d;
      r_idx   <= w_idx_d;
      r_digit <= w_digit_d;
      r_last  <= w_last_d;
      r_valid <= w_valid_d;
      r_err   <= w_err_d;
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = r_valid;
  assign bus.out_digit = r_digit;
  assign bus.out_last  = r_last;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_bcd_digit_serializer.sv
module tb_bcd_digit_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_digit_serializer_if #(.DIGIT(7)) bus1 ();
  bcd_digit_serializer_if #(.DIGIT(7)) bus0 ();

  bcd_digit_serializer #(.DIGIT(7), .LZS(1)) dut_lzs1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  bcd_digit_serializer #(.DIGIT(7), .LZS(0)) dut_lzs0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  int passed = 0;
  int total  = 0;
  logic [3:0] exp_q[$];

  // Reference: decimal digits MS first, leading zeros stripped when lzs=1,
  // but the units digit is always emitted.
  function automatic void build_exp(input logic [27:0] w, input bit lzs);
    bit started;
    logic [3:0] nib;
    exp_q.delete();
    started = !lzs;
    for (int i = 6; i >= 0; i--) begin
      nib = w[i*4 +: 4];
      if (nib != 4'd0 || i == 0) started = 1'b1;
      if (started) exp_q.push_back(nib);
    end
  endfunction

  function automatic bit has_bad(input logic [27:0] w);
    bit b;
    b = 1'b0;
    for (int i = 0; i < 7; i++) if (w[i*4 +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: out_ready high; 1: random stalls; 2: three stalls before digit 1
  // with a competing in_valid during the stall.
  task automatic do_word(input logic [27:0] w, input int mode, input string name);
    bit bad;
    int k, guard, stalls, n;
    bit stall;
    logic exp_last;
    bad = has_bad(w);
    build_exp(w, 1'b1);
    n = exp_q.size();
    bus1.BCD_code = w;
    bus1.in_valid = 1'b1;
    bus1.out_ready = 1'b0;
    tick();
    bus1.in_valid = 1'b0;
    if (bad) begin
      total++; if (bus1.err !== 1'b1) $display("FAIL %s err_pulse: got %b want 1", name, bus1.err); else passed++;
      total++; if (bus1.out_valid !== 1'b0) $display("FAIL %s bad_valid: got %b want 0", name, bus1.out_valid); else passed++;
      total++; if (bus1.in_ready !== 1'b1) $display("FAIL %s bad_ready: got %b want 1", name, bus1.in_ready); else passed++;
      tick();
      total++; if (bus1.err !== 1'b0) $display("FAIL %s err_once: got %b want 0", name, bus1.err); else passed++;
      total++; if (bus1.out_valid !== 1'b0) $display("FAIL %s bad_valid2: got %b want 0", name, bus1.out_valid); else passed++;
      return;
    end
    total++; if (bus1.in_ready !== 1'b0) $display("FAIL %s busy_ready: got %b want 0", name, bus1.in_ready); else passed++;
    k = 0; guard = 0; stalls = 0;
    while (k < n && guard < 200) begin
      guard++;
      exp_last = (k == n - 1);
      total++; if (bus1.out_valid !== 1'b1) $display("FAIL %s valid[%0d]: got %b want 1", name, k, bus1.out_valid); else passed++;
      total++; if (bus1.out_digit !== exp_q[k]) $display("FAIL %s digit[%0d]: got %0d want %0d", name, k, bus1.out_digit, exp_q[k]); else passed++;
      total++; if (bus1.out_last !== exp_last) $display("FAIL %s last[%0d]: got %b want %b", name, k, bus1.out_last, exp_last); else passed++;
      total++; if (bus1.err !== 1'b0) $display("FAIL %s err_send[%0d]: got %b want 0", name, k, bus1.err); else passed++;
      if (mode == 1) stall = ($urandom_range(0, 99) < 30);
      else if (mode == 2) stall = (k == 1 && stalls < 3);
      else stall = 1'b0;
      if (stall) begin
        stalls++;
        bus1.out_ready = 1'b0;
        if (mode == 2) begin
          bus1.in_valid = 1'b1;
          bus1.BCD_code = 28'h0000333;
        end
        tick();
        bus1.in_valid = 1'b0;
        total++; if (bus1.in_ready !== 1'b0) $display("FAIL %s stall_ready: got %b want 0", name, bus1.in_ready); else passed++;
      end else begin
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        k++;
      end
    end
    total++; if (k != n) $display("FAIL %s timeout: got %0d digits want %0d", name, k, n); else passed++;
    total++; if (bus1.out_valid !== 1'b0) $display("FAIL %s end_valid: got %b want 0", name, bus1.out_valid); else passed++;
    total++; if (bus1.out_last !== 1'b0) $display("FAIL %s end_last: got %b want 0", name, bus1.out_last); else passed++;
    total++; if (bus1.in_ready !== 1'b1) $display("FAIL %s end_ready: got %b want 1", name, bus1.in_ready); else passed++;
  endtask

  task automatic test_reset();
    bus1.in_valid = 1'b0; bus1.BCD_code = '0; bus1.out_ready = 1'b0;
    bus0.in_valid = 1'b0; bus0.BCD_code = '0; bus0.out_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    total++; if (bus1.out_valid !== 1'b0) $display("FAIL rst out_valid: got %b want 0", bus1.out_valid); else passed++;
    total++; if (bus1.out_digit !== 4'd0) $display("FAIL rst out_digit: got %0d want 0", bus1.out_digit); else passed++;
    total++; if (bus1.out_last !== 1'b0) $display("FAIL rst out_last: got %b want 0", bus1.out_last); else passed++;
    total++; if (bus1.err !== 1'b0) $display("FAIL rst err: got %b want 0", bus1.err); else passed++;
    total++; if (bus1.in_ready !== 1'b1) $display("FAIL rst in_ready: got %b want 1", bus1.in_ready); else passed++;
    total++; if (bus0.in_ready !== 1'b1) $display("FAIL rst in_ready0: got %b want 1", bus0.in_ready); else passed++;
    #14;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    do_word(28'h0001234, 0, "w1234");
    do_word(28'h0000000, 0, "wzero");
    do_word(28'h1048575, 0, "wmax");
  endtask

  task automatic test_backpressure();
    do_word(28'h0000907, 2, "bp907");
  endtask

  task automatic test_invalid();
    do_word(28'h00000A0, 0, "badA0");
    do_word(28'h0000005, 0, "after_bad");
  endtask

  task automatic test_reset_mid();
    bus1.BCD_code = 28'h0001234;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    total++; if (bus1.out_digit !== 4'd2) $display("FAIL rstmid digit2: got %0d want 2", bus1.out_digit); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus1.out_valid !== 1'b0) $display("FAIL rstmid valid: got %b want 0", bus1.out_valid); else passed++;
    total++; if (bus1.in_ready !== 1'b1) $display("FAIL rstmid ready: got %b want 1", bus1.in_ready); else passed++;
    #2;
    rst_n = 1'b1;
    tick();
    total++; if (bus1.out_valid !== 1'b0) $display("FAIL rstmid no_resume: got %b want 0", bus1.out_valid); else passed++;
    do_word(28'h0000042, 0, "post_rst42");
  endtask

  task automatic test_lzs0();
    logic exp_last;
    build_exp(28'h0000042, 1'b0);
    bus0.BCD_code = 28'h0000042;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    bus0.out_ready = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      exp_last = (k == exp_q.size() - 1);
      total++; if (bus0.out_valid !== 1'b1) $display("FAIL lzs0 valid[%0d]: got %b want 1", k, bus0.out_valid); else passed++;
      total++; if (bus0.out_digit !== exp_q[k]) $display("FAIL lzs0 digit[%0d]: got %0d want %0d", k, bus0.out_digit, exp_q[k]); else passed++;
      total++; if (bus0.out_last !== exp_last) $display("FAIL lzs0 last[%0d]: got %b want %b", k, bus0.out_last, exp_last); else passed++;
      tick();
    end
    bus0.out_ready = 1'b0;
    total++; if (bus0.out_valid !== 1'b0) $display("FAIL lzs0 end_valid: got %b want 0", bus0.out_valid); else passed++;
    total++; if (bus0.in_ready !== 1'b1) $display("FAIL lzs0 end_ready: got %b want 1", bus0.in_ready); else passed++;
  endtask

  task automatic test_random();
    logic [27:0] w;
    int nlead;
    for (int t = 0; t < 25; t++) begin
      nlead = $urandom_range(0, 7);
      w = '0;
      for (int i = 0; i < 7; i++) begin
        if (i < 7 - nlead) w[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) w[$urandom_range(0, 6)*4 +: 4] = 4'($urandom_range(10, 15));
      do_word(w, 1, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_invalid();
    test_reset_mid();
    test_lzs0();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
